huffman_block_scheduler: RTL and testbench

- Shares one downstream Huffman encode datapath between three per-component record streams (Y, Cb, Cr), each carrying tempCode_t records.
- Grants whole 8x8 blocks in MCU order: Y_BLOCKS Y blocks, then C_BLOCKS Cb, then C_BLOCKS Cr, repeated for mcu_total MCUs per frame.
- Tags each forwarded record with its component id, which the encoder uses as the DC/AC table select.
- Sits between the per-component RLE stages and the Huffman encoder/bit packer.

---
 rtl/huffman_block_scheduler_pkg.sv | 18 +
 rtl/huffman_block_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_huffman_block_scheduler.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/huffman_block_scheduler_pkg.sv
// Record type shared by the RLE stages, the block scheduler and the Huffman encoder.
package huffman_block_scheduler_pkg;

  localparam int unsigned RUN_W  = 4;
  localparam int unsigned SIZE_W = 4;
  localparam int unsigned AMP_W  = 12;

  // One run-length record; valid is the stream strobe, done marks the last record of a block.
  typedef struct packed {
    logic              valid;
    logic              done;
    logic              isDC;
    logic [RUN_W-1:0]  run;
    logic [SIZE_W-1:0] size;
    logic [AMP_W-1:0]  amp;
  } tempCode_t;

endpackage

// File: rtl/huffman_block_scheduler.sv
// Arbitrates Y/Cb/Cr record streams onto one Huffman datapath in MCU block order.
module huffman_block_scheduler
  import huffman_block_scheduler_pkg::*;
#(
  parameter int unsigned Y_BLOCKS = 4,
  parameter int unsigned C_BLOCKS = 1,
  parameter int unsigned MCU_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MCU_W-1:0] mcu_total,
  input  tempCode_t        in_code [0:2],
  output logic [2:0]       in_ready,
  output tempCode_t        out_code,
  output logic [1:0]       out_comp,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done,
  output logic             seq_err
);

  localparam int unsigned BLK_MAX = (Y_BLOCKS > C_BLOCKS) ? Y_BLOCKS : C_BLOCKS;
  localparam int unsigned BLK_W   = $clog2(BLK_MAX + 1);
  localparam logic [BLK_W-1:0] Y_LAST = BLK_W'(Y_BLOCKS - 1);
  localparam logic [BLK_W-1:0] C_LAST = BLK_W'(C_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_Y,
    S_CB,
    S_CR,
    S_FLUSH
  } state_e;

  state_e           state_q, state_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [MCU_W-1:0] mcu_cnt_q, mcu_cnt_d;
  logic [MCU_W-1:0] mcu_total_q, mcu_total_d;
  tempCode_t        out_code_q, out_code_d;
  logic [1:0]       out_comp_q, out_comp_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             seq_err_q, seq_err_d;
  logic             first_q, first_d;

  logic             granted_c;
  logic [1:0]       grant_c;
  tempCode_t        sel_code_c;
  logic             out_free_c;
  logic             xfer_c;
  logic             blk_last_c;

  // Select the granted stream from the current phase.
  always_comb begin
    granted_c  = 1'b0;
    grant_c    = 2'd0;
    sel_code_c = in_code[0];
    blk_last_c = (blk_cnt_q == C_LAST);
    case (state_q)
      S_Y: begin
        granted_c  = 1'b1;
        grant_c    = 2'd0;
        sel_code_c = in_code[0];
        blk_last_c = (blk_cnt_q == Y_LAST);
      end
      S_CB: begin
        granted_c  = 1'b1;
        grant_c    = 2'd1;
        sel_code_c = in_code[1];
      end
      S_CR: begin
        granted_c  = 1'b1;
        grant_c    = 2'd2;
        sel_code_c = in_code[2];
      end
      default: ;
    endcase
  end

  assign out_free_c = !out_code_q.valid || out_ready;
  assign xfer_c     = granted_c && out_free_c && sel_code_c.valid;
  assign in_ready   = (granted_c && out_free_c) ? 3'(3'b001 << grant_c) : 3'b000;

  // Next-state, counters, output register and DC/AC ordering check.
  always_comb begin
    state_d      = state_q;
    blk_cnt_d    = blk_cnt_q;
    mcu_cnt_d    = mcu_cnt_q;
    mcu_total_d  = mcu_total_q;
    out_code_d   = out_code_q;
    out_comp_d   = out_comp_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    seq_err_d    = seq_err_q;
    first_d      = first_q;

    if (xfer_c) begin
      out_code_d = sel_code_c;
      out_comp_d = grant_c;
      // A block must open with exactly one DC record.
      if (first_q != sel_code_c.isDC) seq_err_d = 1'b1;
      first_d = sel_code_c.done;
    end else if (out_ready) begin
      out_code_d.valid = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcu_total_d = mcu_total;
          seq_err_d   = 1'b0;
          busy_d      = 1'b1;
          blk_cnt_d   = '0;
          mcu_cnt_d   = '0;
          first_d     = 1'b1;
          state_d     = (mcu_total == '0) ? S_FLUSH : S_Y;
        end
      end
      S_Y, S_CB, S_CR: begin
        if (xfer_c && sel_code_c.done) begin
          if (blk_last_c) begin
            blk_cnt_d = '0;
            case (state_q)
              S_Y:  state_d = S_CB;
              S_CB: state_d = S_CR;
              default: begin
                mcu_cnt_d = mcu_cnt_q + 1'b1;
                state_d   = (mcu_cnt_d == mcu_total_q) ? S_FLUSH : S_Y;
              end
            endcase
          end else begin
            blk_cnt_d = blk_cnt_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        // Finish once the last record has left the output register.
        if (out_free_c) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      blk_cnt_q    <= '0;
      mcu_cnt_q    <= '0;
      mcu_total_q  <= '0;
      out_code_q   <= '0;
      out_comp_q   <= 2'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
      first_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      blk_cnt_q    <= blk_cnt_d;
      mcu_cnt_q    <= mcu_cnt_d;
      mcu_total_q  <= mcu_total_d;
      out_code_q   <= out_code_d;
      out_comp_q   <= out_comp_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      seq_err_q    <= seq_err_d;
      first_q      <= first_d;
    end
  end

  assign out_code   = out_code_q;
  assign out_comp   = out_comp_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_huffman_block_scheduler.sv
// Scoreboard bench for huffman_block_scheduler: drivers feed per-stream queues, a monitor checks outputs.
module tb_huffman_block_scheduler;
  import huffman_block_scheduler_pkg::*;

  localparam int Y = 4;
  localparam int C = 1;
  localparam int unsigned MW = 16;

  typedef struct {
    tempCode_t  code;
    logic [1:0] comp;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [MW-1:0] mcu_total;
  tempCode_t     in_code [0:2];
  logic [2:0]    in_ready;
  tempCode_t     out_code;
  logic [1:0]    out_comp;
  logic          out_ready;
  logic          busy;
  logic          frame_done;
  logic          seq_err;

  huffman_block_scheduler #(.Y_BLOCKS(Y), .C_BLOCKS(C), .MCU_W(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcu_total(mcu_total),
    .in_code(in_code), .in_ready(in_ready), .out_code(out_code), .out_comp(out_comp),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  tempCode_t src [3][$];
  exp_t      exp_q [$];

  // Reference model state (owned by the monitor, cleared by the main sequence on reset).
  int  cyc = 0;
  int  fd_cnt = 0;
  int  fd_exp_cyc = -1;
  bit  tb_busy = 0;
  int  m_total = 0;
  int  ydone = 0, cbdone = 0, crdone = 0;
  int  out_left = 0;
  bit  hold_pend = 0;
  tempCode_t  hold_rec;
  logic [1:0] hold_comp;
  int  mode = 0;
  int  ocnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Build one frame: stream queues plus the expected output order.
  task automatic load_frame(input int t, input bit bad);
    exp_t e;
    tempCode_t r;
    for (int m = 0; m < t; m++) begin
      for (int c = 0; c < 3; c++) begin
        for (int b = 0; b < ((c == 0) ? Y : C); b++) begin
          for (int k = 0; k < 3; k++) begin
            r.valid = 1'b1;
            r.done  = (k == 2);
            r.isDC  = (k == 0) && !(bad && m == 0 && c == 0 && b == 0);
            r.run   = 4'(k);
            r.size  = 4'(b);
            r.amp   = {2'(c), 6'(m), 2'(b), 2'(k)};
            src[c].push_back(r);
            e.code = r;
            e.comp = 2'(c);
            exp_q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic pulse_start(input int t);
    @(negedge clk);
    start = 1'b1;
    mcu_total = MW'(t);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_fd(input int target);
    int n = 0;
    while (fd_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (fd_cnt < target) chk("frame_timeout", 64'(fd_cnt), 64'(target));
    repeat (3) @(negedge clk);
    chk("frame_done_count", 64'(fd_cnt), 64'(target));
    chk("records_left", 64'(exp_q.size()), 64'd0);
    chk("busy_after_frame", 64'(busy), 64'd0);
  endtask

  task automatic run_frame(input int t, input bit bad);
    int target;
    target = fd_cnt + 1;
    load_frame(t, bad);
    pulse_start(t);
    chk("seq_err_after_start", 64'(seq_err), 64'd0);
    wait_fd(target);
    chk("seq_err_end", 64'(seq_err), 64'(bad));
  endtask

  // Input/backpressure driver, updated on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        in_code[i] = (src[i].size() != 0) ? src[i][0] : '0;
      ocnt++;
      out_ready = (mode == 0) ? 1'b1 : ((ocnt % 4 == 0) || (ocnt % 4 == 3));
    end
  end

  // Monitor: samples pre-edge handshakes, checks grants, outputs, hold and latency.
  initial begin
    logic [2:0] p_ready, exp_ready;
    tempCode_t  p_oc, lat_rec;
    tempCode_t  p_in [0:2];
    logic [1:0] p_comp, lat_comp;
    logic       p_or, p_fd, p_busy, p_start;
    logic [MW-1:0] p_tot;
    bit  lat_pend;
    int  eg, mi;
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        cyc++;
        p_ready = in_ready; p_oc = out_code; p_comp = out_comp; p_or = out_ready;
        p_fd = frame_done; p_busy = busy; p_start = start; p_tot = mcu_total;
        for (int i = 0; i < 3; i++) p_in[i] = in_code[i];

        if (p_fd) begin
          fd_cnt++;
          tb_busy = 0;
          chk("frame_done_edge", 64'(cyc), 64'(fd_exp_cyc));
        end
        chk("busy", 64'(p_busy), 64'(tb_busy));

        eg = 3;
        if (tb_busy && crdone < C * m_total) begin
          mi = crdone / C;
          if (ydone < Y * (mi + 1)) eg = 0;
          else if (cbdone < C * (mi + 1)) eg = 1;
          else eg = 2;
        end
        exp_ready = 3'b000;
        if (eg < 3) exp_ready[eg] = !p_oc.valid || p_or;
        chk("in_ready", 64'(p_ready), 64'(exp_ready));

        lat_pend = 0;
        for (int i = 0; i < 3; i++) begin
          if (p_in[i].valid && p_ready[i]) begin
            if (src[i].size() == 0) chk("input_underflow", 64'd1, 64'd0);
            else void'(src[i].pop_front());
            lat_pend = 1;
            lat_rec  = p_in[i];
            lat_comp = 2'(i);
            if (p_in[i].done) begin
              if (i == 0) ydone++;
              else if (i == 1) cbdone++;
              else crdone++;
            end
          end
        end

        if (hold_pend) begin
          chk("hold_code", 64'({p_oc}), 64'({hold_rec}));
          chk("hold_comp", 64'(p_comp), 64'(hold_comp));
        end
        hold_pend = p_oc.valid && !p_or;
        hold_rec  = p_oc;
        hold_comp = p_comp;

        if (p_oc.valid && p_or) begin
          if (exp_q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("out_code", 64'({p_oc}), 64'({e.code}));
            chk("out_comp", 64'(p_comp), 64'(e.comp));
            out_left--;
            if (out_left == 0) fd_exp_cyc = cyc + 1;
          end
        end

        if (p_start && !tb_busy) begin
          tb_busy = 1;
          m_total = int'(p_tot);
          ydone = 0; cbdone = 0; crdone = 0;
          out_left = (Y + 2 * C) * 3 * m_total;
          if (m_total == 0) fd_exp_cyc = cyc + 2;
        end

        #1;
        if (lat_pend) begin
          chk("latency_code", 64'({out_code}), 64'({lat_rec}));
          chk("latency_comp", 64'(out_comp), 64'(lat_comp));
        end
      end
    end
  end

  // Directed test sequence.
  initial begin
    int target;
    rst_n = 1'b0;
    start = 1'b0;
    mcu_total = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) in_code[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_code", 64'({out_code}), 64'd0);
    chk("rst_out_comp", 64'(out_comp), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_seq_err", 64'(seq_err), 64'd0);
    rst_n = 1'b1;

    // One MCU at full throughput, then under 1,0,0,1 backpressure.
    mode = 0;
    run_frame(1, 0);
    mode = 1;
    ocnt = 0;
    run_frame(1, 0);
    mode = 0;

    // Ordering violation is flagged, then cleared by the next start.
    run_frame(1, 1);
    run_frame(1, 0);

    // Empty frame.
    run_frame(0, 0);

    // Start pulse mid-frame must be ignored.
    target = fd_cnt + 1;
    load_frame(1, 0);
    pulse_start(1);
    repeat (8) @(negedge clk);
    start = 1'b1;
    mcu_total = MW'(5);
    @(negedge clk);
    start = 1'b0;
    wait_fd(target);

    // Asynchronous reset mid-block, then a fresh two-MCU frame.
    load_frame(2, 0);
    pulse_start(2);
    repeat (5) @(negedge clk);
    #2;
    chk("pre_reset_valid", 64'(out_code.valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_code.valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) src[i].delete();
    exp_q.delete();
    tb_busy = 0; hold_pend = 0; m_total = 0; out_left = 0; fd_exp_cyc = -1;
    ydone = 0; cbdone = 0; crdone = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
